// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART serializer: circular byte buffer plus a
// four-state sender that strobes one byte at a time while the serializer is free.
module uart_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk100,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          ovf_clr,
    input  logic          tx_busy,
    output logic [7:0]    tx_byte,
    output logic          tx_send,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          idle
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

    state_t         state, state_n;
    logic [7:0]     mem [2**AW];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           wr_ok, pop;

    assign full  = (level == DEPTH);
    assign empty = (level == '0);
    assign idle  = empty && (state == S_IDLE) && !tx_busy;
    // full is the pre-edge level, so a pop in the same cycle never frees a slot for this write
    assign wr_ok = wr_en && !full;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_n = S_SEND;
                end
            end
            S_SEND:  state_n = S_GUARD;
            // serializer raises busy one cycle after sampling the strobe; skip that gap
            S_GUARD: state_n = S_WAIT;
            S_WAIT:  if (!tx_busy) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx_send  <= 1'b0;
            tx_byte  <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            tx_send <= pop;
            if (pop) begin
                tx_byte <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (wr_en && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk100) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a serializer busy model and a byte
// scoreboard checked on every send strobe.
module tb_uart_tx_fifo;

    logic       clk100 = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en, ovf_clr;
    logic       tx_busy;
    logic [7:0] tx_byte;
    logic       tx_send, full, empty, overflow, idle;
    logic [4:0] level;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    int   cyc = 0;
    int   pulses = 0;
    int   last_pulse = -1;
    bit   gap_en = 0;
    bit   hold = 0;
    int   busy_dur = 20;
    logic mbusy;
    int   mcnt;

    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc++;

    assign tx_busy = hold | mbusy;

    uart_tx_fifo #(.AW(4)) dut (
        .clk100(clk100), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .ovf_clr(ovf_clr), .tx_busy(tx_busy), .tx_byte(tx_byte), .tx_send(tx_send),
        .full(full), .empty(empty), .level(level), .overflow(overflow), .idle(idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serializer model: busy from the cycle after it samples tx_send, low again busy_dur clocks after the send.
    always @(posedge clk100 or posedge reset) begin
        if (reset) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (!mbusy && tx_send) begin
            mbusy <= 1'b1;
            mcnt  <= busy_dur - 2;
        end else if (mbusy) begin
            if (mcnt == 0) mbusy <= 1'b0;
            else           mcnt  <= mcnt - 1;
        end
    end

    always @(negedge clk100) begin
        if (!reset && tx_send) begin
            pulses++;
            chk("busy_at_send", tx_busy, 0);
            if (sb.size() == 0) begin
                chk("unexpected_send", 1, 0);
            end else begin
                chk("tx_byte_order", tx_byte, sb.pop_front());
            end
            if (gap_en && last_pulse >= 0)
                chk("pulse_gap_1050_1052", (cyc - last_pulse >= 1050) && (cyc - last_pulse <= 1052), 1);
            last_pulse = cyc;
        end
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit accept);
        wr_data = d;
        wr_en   = 1'b1;
        if (accept) sb.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (!(idle && sb.size() == 0) && n < max) begin
            tick();
            n++;
        end
        chk(tag, n < max, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_send"}, tx_send, 0);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int p0;
        reset = 1'b1; wr_data = 8'h00; wr_en = 1'b0; ovf_clr = 1'b0;
        #22;
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // single byte: strobe two edges after the write
        wr(8'hA5, 1);
        chk("a5_level1", level, 1);
        chk("a5_send_early", tx_send, 0);
        tick();
        chk("a5_send", tx_send, 1);
        chk("a5_byte", tx_byte, 8'hA5);
        chk("a5_level0", level, 0);
        tick();
        chk("a5_send_1cyc", tx_send, 0);
        chk("a5_not_idle", idle, 0);
        wait_idle("a5_drain", 200);
        chk("a5_pulses", pulses, 1);

        // five bytes at the real frame length
        busy_dur = 1050; gap_en = 1; last_pulse = -1; p0 = pulses;
        for (int i = 1; i <= 5; i++) wr(8'(i), 1);
        wait_idle("burst5_drain", 6000);
        chk("burst5_pulses", pulses - p0, 5);
        gap_en = 0; busy_dur = 20;

        // overflow with a stalled sender
        hold = 1; p0 = pulses;
        for (int i = 0; i < 20; i++) wr(8'h40 + 8'(i), i < 16);
        chk("ovf_level16", level, 16);
        chk("ovf_full", full, 1);
        chk("ovf_set", overflow, 1);
        hold = 0;
        wait_idle("ovf_drain", 2000);
        chk("ovf_pulses16", pulses - p0, 16);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1; tick(); ovf_clr = 0;
        chk("ovf_clr", overflow, 0);

        // full FIFO, pop and dropped write in the same edge; set beats clear
        hold = 1;
        for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 1);
        hold = 0; ovf_clr = 1;
        wr(8'hEE, 0);
        ovf_clr = 0;
        chk("fullpop_level15", level, 15);
        chk("fullpop_ovf", overflow, 1);
        chk("fullpop_send", tx_send, 1);
        wait_idle("fullpop_drain", 2000);
        ovf_clr = 1; tick(); ovf_clr = 0;

        // half-full, accepted write alongside a pop
        hold = 1;
        for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i), 1);
        chk("half_level8", level, 8);
        hold = 0;
        wr(8'hC8, 1);
        chk("half_level_same", level, 8);
        chk("half_ovf", overflow, 0);
        wait_idle("half_drain", 2000);

        // wrap-around: 40 bytes in bursts of 8
        p0 = pulses;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 8; i++) begin
                wr(8'(b * 8 + i + 16), 1);
                chk("wrap_level_le8", level <= 8, 1);
            end
            wait_idle("wrap_drain", 1000);
        end
        chk("wrap_pulses40", pulses - p0, 40);

        // reset mid-frame
        for (int i = 0; i < 3; i++) wr(8'hD0 + 8'(i), 1);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        sb.delete();
        p0 = pulses;
        tick();
        reset = 1'b0;
        repeat (50) tick();
        chk("midrst_no_send", pulses - p0, 0);
        chk("midrst_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
